// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus byte-strobed data RAM port for the MEM-stage load/store unit.
// The slave modport is the LSU. The master modport is the pipeline and RAM side.
interface dmem_lsu_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [31:0] addr_dmem_ram_o;
   logic [31:0] wr_data_dmem_ram_o;
   logic [0:3]  wr_strb_dmem_ram_o;
   logic        wr_en_dmem_ram_o;
   logic [31:0] read_data_dmem_ram_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
             read_data_dmem_ram_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
             addr_dmem_ram_o, wr_data_dmem_ram_o, wr_strb_dmem_ram_o, wr_en_dmem_ram_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
             read_data_dmem_ram_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
             addr_dmem_ram_o, wr_data_dmem_ram_o, wr_strb_dmem_ram_o, wr_en_dmem_ram_o
   );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator. It issues one or two word accesses per request.
// It aligns store lanes and sign- or zero-extends load data.
module dmem_lsu #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input logic       clk,
   input logic       reset,
   dmem_lsu_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state;
   logic        we_q, uns_q;
   logic [1:0]  size_q, off_q;
   logic [29:0] word_q;
   logic [31:0] wdata_q, lo_buf;
   logic [3:0]  mask_hi_q;

   logic [1:0]  off_in;
   logic [3:0]  lane_base;
   logic [7:0]  mask_in;
   logic        bad_in;
   logic [31:0] wdata_lo_in, wdata_hi;

   // strb bit n covers bits [8n+7:8n], so map by index rather than by packed position
   function automatic logic [0:3] to_strb(input logic [3:0] m);
      logic [0:3] s;
      for (int n = 0; n < 4; n++) s[n] = m[n];
      return s;
   endfunction

   function automatic logic [31:0] load_ext(input logic [63:0] dw, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
      logic [63:0] sh;
      logic [31:0] r;
      sh = dw >> {off, 3'b000};
      case (size)
         2'd0:    r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'd1:    r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: r = sh[31:0];
      endcase
      return r;
   endfunction

   always_comb begin
      off_in = bus.req_addr_i[1:0];
      case (bus.req_size_i)
         2'd0:    lane_base = 4'h1;
         2'd1:    lane_base = 4'h3;
         default: lane_base = 4'hF;
      endcase
      mask_in     = {4'h0, lane_base} << off_in;
      bad_in      = (bus.req_size_i == 2'd3) || ((|mask_in[7:4]) && !ALLOW_MISALIGNED);
      wdata_lo_in = bus.req_wdata_i << {off_in, 3'b000};
      // only reached with off_q != 0, so the shift stays below 32
      wdata_hi    = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= IDLE;
         bus.req_ready_o        <= 1'b1;
         bus.rsp_valid_o        <= 1'b0;
         bus.rsp_err_o          <= 1'b0;
         bus.rsp_rdata_o        <= '0;
         bus.addr_dmem_ram_o    <= '0;
         bus.wr_data_dmem_ram_o <= '0;
         bus.wr_strb_dmem_ram_o <= '0;
         bus.wr_en_dmem_ram_o   <= 1'b0;
         we_q                   <= 1'b0;
         uns_q                  <= 1'b0;
         size_q                 <= '0;
         off_q                  <= '0;
         word_q                 <= '0;
         wdata_q                <= '0;
         lo_buf                 <= '0;
         mask_hi_q              <= '0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid_i) begin
               we_q            <= bus.req_we_i;
               uns_q           <= bus.req_unsigned_i;
               size_q          <= bus.req_size_i;
               off_q           <= off_in;
               word_q          <= bus.req_addr_i[31:2];
               wdata_q         <= bus.req_wdata_i;
               mask_hi_q       <= mask_in[7:4];
               bus.req_ready_o <= 1'b0;
               if (bad_in) begin
                  state           <= DONE;
                  bus.rsp_valid_o <= 1'b1;
                  bus.rsp_err_o   <= 1'b1;
               end else begin
                  state                  <= LO;
                  bus.addr_dmem_ram_o    <= {bus.req_addr_i[31:2], 2'b00};
                  bus.wr_data_dmem_ram_o <= wdata_lo_in;
                  bus.wr_strb_dmem_ram_o <= to_strb(mask_in[3:0]);
                  bus.wr_en_dmem_ram_o   <= bus.req_we_i;
               end
            end
            LO: begin
               lo_buf <= bus.read_data_dmem_ram_i;
               if (|mask_hi_q) begin
                  state                  <= HI;
                  bus.addr_dmem_ram_o    <= {word_q + 30'd1, 2'b00};
                  bus.wr_data_dmem_ram_o <= wdata_hi;
                  bus.wr_strb_dmem_ram_o <= to_strb(mask_hi_q);
                  bus.wr_en_dmem_ram_o   <= we_q;
               end else begin
                  state                  <= DONE;
                  bus.addr_dmem_ram_o    <= '0;
                  bus.wr_data_dmem_ram_o <= '0;
                  bus.wr_strb_dmem_ram_o <= '0;
                  bus.wr_en_dmem_ram_o   <= 1'b0;
                  bus.rsp_valid_o        <= 1'b1;
                  bus.rsp_rdata_o        <= we_q ? '0 :
                     load_ext({32'h0, bus.read_data_dmem_ram_i}, off_q, size_q, uns_q);
               end
            end
            HI: begin
               // the high word is consumed on the same edge it is sampled
               state                  <= DONE;
               bus.addr_dmem_ram_o    <= '0;
               bus.wr_data_dmem_ram_o <= '0;
               bus.wr_strb_dmem_ram_o <= '0;
               bus.wr_en_dmem_ram_o   <= 1'b0;
               bus.rsp_valid_o        <= 1'b1;
               bus.rsp_rdata_o        <= we_q ? '0 :
                  load_ext({bus.read_data_dmem_ram_i, lo_buf}, off_q, size_q, uns_q);
            end
            DONE: begin
               state           <= IDLE;
               bus.rsp_valid_o <= 1'b0;
               bus.rsp_err_o   <= 1'b0;
               bus.rsp_rdata_o <= '0;
               bus.req_ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule
